instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL provide parameter RESET_VECTOR, default 32'hBFC00000, the address of the first fetch after reset.
REQ-002 SHALL provide parameter HALT_ADDR, default 32'h00000000; a fetch target equal to it halts the CPU.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port avm_address, output, 32, word-aligned instruction address.
REQ-006 SHALL have port avm_read, output, 1, read request.
REQ-007 SHALL have port avm_waitrequest, input, 1, memory stall; the request is held while it is high.
REQ-008 SHALL have port avm_readdata, input, 32, instruction word, valid on the cycle waitrequest is low.
REQ-009 SHALL have port inst, output, 32, registered instruction for decode/control.
REQ-010 SHALL have port inst_valid, output, 1, inst holds a fetched, unconsumed instruction.
REQ-011 SHALL have port inst_ack, input, 1, downstream consumed inst (end of instruction).
REQ-012 SHALL have port pc_out, output, 32, address of the instruction in inst.
REQ-013 SHALL have port redirect, input, 1, current instruction is a taken branch/jump/JR.
REQ-014 SHALL have port redirect_target, input, 32, branch/jump destination.
REQ-015 SHALL have port active, output, 1, high from the first cycle after reset until halt.

Function
REQ-016 SHALL implement the states FETCH, ISSUE and HALTED.
REQ-017 FETCH: avm_read=1 and avm_address=pc; address and read SHALL stay stable while avm_waitrequest=1.
REQ-018 FETCH: on the first cycle with avm_waitrequest=0, SHALL register avm_readdata into inst and pc into pc_out, then enter ISSUE.
REQ-019 Latency with zero wait states SHALL be 1 cycle from avm_read high to inst_valid high.
REQ-020 ISSUE: inst_valid=1 and avm_read=0; inst and pc_out SHALL be held until inst_ack=1.
REQ-021 inst_ack SHALL be ignored when inst_valid=0.
REQ-022 redirect and redirect_target SHALL be sampled only on the cycle where inst_valid and inst_ack are both high.
REQ-023 Branch delay slot: a sampled redirect SHALL set pending=1 and store target; the next fetch SHALL still be pc+4.
REQ-024 On ack of the delay-slot instruction with pending=1, next pc SHALL be the stored target and pending SHALL clear.
REQ-025 redirect asserted during ack of a delay-slot instruction SHALL be ignored; the pending target wins.
REQ-026 redirect_target[1:0] SHALL be forced to 2'b00.
REQ-027 pc+4 SHALL wrap modulo 2^32.
REQ-028 On ack: if next pc == HALT_ADDR, SHALL enter HALTED; otherwise SHALL enter FETCH on the next cycle.
REQ-029 HALTED: avm_read=0, inst_valid=0 and active=0; only reset exits HALTED.

Reset
REQ-030 While reset=1: pc=RESET_VECTOR, state=FETCH, pending=0, inst=0, pc_out=0, inst_valid=0, avm_read=0, active=0.
REQ-031 Reset during an outstanding read (waitrequest high) SHALL abort it; avm_read SHALL be low the cycle after reset is sampled, and the late readdata SHALL be discarded.
REQ-032 On the first cycle after reset deasserts: avm_read=1, avm_address=RESET_VECTOR, active=1.

Structure
REQ-033 Package fetch_pkg SHALL hold the state enum typedef and the RESET_VECTOR and HALT_ADDR default constants.
REQ-034 SHALL be a single module with no sub-modules; the next-pc mux and the state FSM live inline.

Verification
REQ-035 Reset release, zero wait states, ack each instruction -> addresses BFC00000, BFC00004, BFC00008 issued, each inst_valid 1 cycle after its read.
REQ-036 waitrequest held high 3 cycles on BFC00000 -> avm_address and avm_read stable for 4 cycles; inst captures readdata from the 4th cycle only.
REQ-037 Ack of BFC00004 with redirect=1, target=BFC00103 -> next fetch BFC00008 (delay slot); after its ack, fetch BFC00100.
REQ-038 JR to 0: redirect target=0, then delay slot acked -> HALTED, active=0, avm_read=0 held for 10 cycles.
REQ-039 Reset asserted mid-read with waitrequest=1 -> avm_read low the next cycle; after release, fetch restarts at BFC00000 and pending=0.
REQ-040 inst_valid held 5 cycles with inst_ack=0 -> inst and pc_out unchanged, no avm_read issued.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   localparam logic [31:0] FETCH_RESET_VECTOR = 32'hBFC0_0000;
   localparam logic [31:0] FETCH_HALT_ADDR    = 32'h0000_0000;

   // Instruction addresses are always word aligned; drop the byte offset.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: fetches one word over Avalon-MM, holds it for
// decode until acknowledged, and sequences the next PC with one branch
// delay slot. A fetch target equal to HALT_ADDR stops the unit until reset.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = FETCH_RESET_VECTOR,
   parameter logic [31:0] HALT_ADDR    = FETCH_HALT_ADDR
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   input  logic        inst_ack,
   output logic [31:0] pc_out,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        active
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  inst_q, inst_d;
   logic [31:0]  pc_out_q, pc_out_d;
   logic         pending_q, pending_d;
   logic [31:0]  target_q, target_d;
   logic [31:0]  next_pc;

   // Next-state, next-pc mux and capture of the fetched word.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      pc_out_d  = pc_out_q;
      pending_d = pending_q;
      target_d  = target_q;
      next_pc   = pc_q + 32'd4;   // 32-bit add wraps naturally

      case (state_q)
         ST_FETCH: begin
            if (!avm_waitrequest) begin
               inst_d   = avm_readdata;
               pc_out_d = pc_q;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (inst_ack) begin
               if (pending_q) begin
                  // Delay slot retired: jump to the stored target; any
                  // redirect on this ack is ignored.
                  next_pc   = target_q;
                  pending_d = 1'b0;
               end else if (redirect) begin
                  // Branch taken: the delay slot at pc+4 still executes.
                  pending_d = 1'b1;
                  target_d  = word_align(redirect_target);
               end
               pc_d    = next_pc;
               state_d = (next_pc == HALT_ADDR) ? ST_HALTED : ST_FETCH;
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_VECTOR;
         inst_q    <= 32'd0;
         pc_out_q  <= 32'd0;
         pending_q <= 1'b0;
         target_q  <= 32'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         pc_out_q  <= pc_out_d;
         pending_q <= pending_d;
         target_q  <= target_d;
      end
   end

   // Outputs are gated by reset so a read in flight drops immediately and
   // the first fetch is presented on the first cycle reset is low.
   always_comb begin
      avm_address = pc_q;
      avm_read    = (state_q == ST_FETCH)  && !reset;
      inst_valid  = (state_q == ST_ISSUE)  && !reset;
      active      = (state_q != ST_HALTED) && !reset;
      inst        = inst_q;
      pc_out      = pc_out_q;
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_ack;
   logic [31:0] pc_out;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        active;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // Memory model: garbage while stalled, otherwise {addr[15:0], A5A5}.
   assign avm_readdata = avm_waitrequest ? 32'hDEAD_BEEF
                                         : {avm_address[15:0], 16'hA5A5};

   instr_fetch dut (
      .clk             (clk),
      .reset           (reset),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_waitrequest (avm_waitrequest),
      .avm_readdata    (avm_readdata),
      .inst            (inst),
      .inst_valid      (inst_valid),
      .inst_ack        (inst_ack),
      .pc_out          (pc_out),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .active          (active)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_fetch(input string tag, input logic [31:0] addr);
      chk({tag, ".read"},  {31'd0, avm_read},   32'd1);
      chk({tag, ".addr"},  avm_address,         addr);
      chk({tag, ".valid"}, {31'd0, inst_valid}, 32'd0);
   endtask

   task automatic expect_issue(input string tag, input logic [31:0] pc, input logic [31:0] word);
      chk({tag, ".valid"}, {31'd0, inst_valid}, 32'd1);
      chk({tag, ".read"},  {31'd0, avm_read},   32'd0);
      chk({tag, ".inst"},  inst,                word);
      chk({tag, ".pc"},    pc_out,              pc);
   endtask

   task automatic expect_halted(input string tag);
      chk({tag, ".active"}, {31'd0, active},     32'd0);
      chk({tag, ".read"},   {31'd0, avm_read},   32'd0);
      chk({tag, ".valid"},  {31'd0, inst_valid}, 32'd0);
   endtask

   task automatic ack(input logic r, input logic [31:0] t);
      inst_ack        = 1'b1;
      redirect        = r;
      redirect_target = t;
      step();
      inst_ack        = 1'b0;
      redirect        = 1'b0;
      redirect_target = 32'd0;
   endtask

   initial begin
      reset           = 1'b1;
      avm_waitrequest = 1'b0;
      inst_ack        = 1'b0;
      redirect        = 1'b0;
      redirect_target = 32'd0;
      repeat (3) step();

      // Reset state
      chk("rst.read",   {31'd0, avm_read},   32'd0);
      chk("rst.active", {31'd0, active},     32'd0);
      chk("rst.valid",  {31'd0, inst_valid}, 32'd0);
      chk("rst.inst",   inst,                32'd0);
      chk("rst.pc_out", pc_out,              32'd0);
      chk("rst.addr",   avm_address,         32'hBFC0_0000);

      // Release: first fetch at the reset vector, zero wait states
      reset = 1'b0;
      #1;
      expect_fetch("rel", 32'hBFC0_0000);
      chk("rel.active", {31'd0, active}, 32'd1);
      step();
      expect_issue("i0", 32'hBFC0_0000, 32'h0000_A5A5);
      ack(1'b0, 32'd0);
      expect_fetch("f1", 32'hBFC0_0004);
      step();
      expect_issue("i1", 32'hBFC0_0004, 32'h0004_A5A5);

      // Branch with delay slot; target low bits dropped
      ack(1'b1, 32'hBFC0_0103);
      expect_fetch("dslot", 32'hBFC0_0008);
      step();
      expect_issue("i2", 32'hBFC0_0008, 32'h0008_A5A5);
      ack(1'b1, 32'h1234_5678);          // ignored: pending target wins
      expect_fetch("tgt", 32'hBFC0_0100);
      step();
      expect_issue("i3", 32'hBFC0_0100, 32'h0100_A5A5);

      // Hold without ack for 5 cycles
      for (int i = 0; i < 5; i++) begin
         step();
         expect_issue("hold", 32'hBFC0_0100, 32'h0100_A5A5);
      end
      ack(1'b0, 32'd0);
      expect_fetch("after_tgt", 32'hBFC0_0104);
      step();
      expect_issue("i4", 32'hBFC0_0104, 32'h0104_A5A5);

      // Reset mid-read with a pending branch
      ack(1'b1, 32'hBFC0_0200);
      avm_waitrequest = 1'b1;
      expect_fetch("stall", 32'hBFC0_0108);
      step();
      expect_fetch("stall2", 32'hBFC0_0108);
      reset = 1'b1;
      step();
      chk("abort.read",   {31'd0, avm_read}, 32'd0);
      chk("abort.active", {31'd0, active},   32'd0);
      reset = 1'b0;
      #1;
      expect_fetch("restart", 32'hBFC0_0000);

      // Three wait states on the reset vector
      for (int i = 0; i < 3; i++) begin
         step();
         expect_fetch("wait", 32'hBFC0_0000);
      end
      avm_waitrequest = 1'b0;
      step();
      expect_issue("wcap", 32'hBFC0_0000, 32'h0000_A5A5);
      ack(1'b0, 32'd0);
      expect_fetch("np1", 32'hBFC0_0004);
      step();
      expect_issue("np1i", 32'hBFC0_0004, 32'h0004_A5A5);
      ack(1'b0, 32'd0);
      expect_fetch("np2", 32'hBFC0_0008);   // stale pending would give BFC00200
      step();
      expect_issue("np2i", 32'hBFC0_0008, 32'h0008_A5A5);

      // JR to 0: delay slot retires, then halt
      ack(1'b1, 32'd0);
      expect_fetch("jr_ds", 32'hBFC0_000C);
      step();
      expect_issue("jr_dsi", 32'hBFC0_000C, 32'h000C_A5A5);
      ack(1'b0, 32'd0);
      expect_halted("halt");
      inst_ack = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         expect_halted("halt_hold");
      end
      inst_ack = 1'b0;

      // Aligned target near the top of memory; pc+4 wraps to 0 and halts
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      expect_fetch("w0", 32'hBFC0_0000);
      step();
      expect_issue("w0i", 32'hBFC0_0000, 32'h0000_A5A5);
      ack(1'b1, 32'hFFFF_FFFF);
      expect_fetch("w1", 32'hBFC0_0004);
      step();
      expect_issue("w1i", 32'hBFC0_0004, 32'h0004_A5A5);
      ack(1'b0, 32'd0);
      expect_fetch("wtop", 32'hFFFF_FFFC);
      step();
      expect_issue("wtopi", 32'hFFFF_FFFC, 32'hFFFC_A5A5);
      ack(1'b0, 32'd0);
      expect_halted("wrap_halt");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
